// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - serial thermometer-code pattern generator (inverse of the ones-counter)
//
// Builds a DATA_WIDTH-bit word with exactly min(count_in, DATA_WIDTH) ones,
// right-justified, shifting in one bit per clock MSB-first. Each shifted bit
// is also presented on ser_out.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request, sampled only while idle
//   count_in   requested number of ones, latched on an accepted start
//   busy       high while the pattern is being built
//   done       one-cycle pulse, data_out valid with it
//   data_out   last completed pattern, held until next completion or reset
//   ser_out    bit inserted on the current shift (holds when ser_valid=0)
//   ser_valid  high on cycles where ser_out is meaningful
//   sat_err    count_in exceeded DATA_WIDTH on the last accepted start

module ones_pattern_gen #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   ser_out,
    output logic                   ser_valid,
    output logic                   sat_err
);

    // Index must reach DATA_WIDTH without wrapping.
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] N_MAX    = COUNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]  data_d;
    logic                   busy_d, done_d, ser_out_d, ser_valid_d, sat_d;
    logic                   bit_in;
    logic                   over;

    always_comb begin
        state_d     = state;
        n_d         = n_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_out;
        busy_d      = busy;
        done_d      = done;
        ser_out_d   = ser_out;
        ser_valid_d = ser_valid;
        sat_d       = sat_err;

        // Zeros come first: the bit is one once idx has passed DATA_WIDTH-n,
        // written as idx+n >= DATA_WIDTH to avoid an unsigned subtraction.
        bit_in = (int'(idx_q) + int'(n_q)) >= DATA_WIDTH;
        over   = int'(count_in) > DATA_WIDTH;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    n_d     = over ? N_MAX : count_in;
                    sat_d   = over;
                    shreg_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_BUILD;
                end
            end
            ST_BUILD: begin
                shreg_d     = {shreg_q[DATA_WIDTH-2:0], bit_in};
                ser_out_d   = bit_in;
                ser_valid_d = 1'b1;
                idx_d       = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    data_d  = {shreg_q[DATA_WIDTH-2:0], bit_in};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d      = 1'b0;
                ser_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            sat_err   <= 1'b0;
        end else begin
            state     <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_out  <= data_d;
            busy      <= busy_d;
            done      <= done_d;
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            sat_err   <= sat_d;
        end
    end

endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Multi-cycle generator: the inverse of the team's serial ones-counter.
- Accepts a population count and builds, one bit per clock, a DATA_WIDTH-bit word containing exactly that many ones, right-justified as a thermometer code.
- Also streams each generated bit on a serial output, so it can drive the counter bench or a serial checker directly.
- Used as a stimulus and pattern source in the Chapter 6 datapath examples.

Parameters:
- DATA_WIDTH, 4, width of the generated word; must be at least 2.
- COUNT_WIDTH, 3, width of the count input; must satisfy 2^COUNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- count_in  input  COUNT_WIDTH  requested number of ones; latched when start is accepted.
- busy  output  1  high while in BUILD.
- done  output  1  one-cycle pulse; data_out is valid with it.
- data_out  output  DATA_WIDTH  last completed pattern; held until the next completion or reset.
- ser_out  output  1  bit inserted on the current shift.
- ser_valid  output  1  high on cycles where ser_out is meaningful.
- sat_err  output  1  count_in exceeded DATA_WIDTH; value updates on each accepted start.

Behaviour:
- Reset, on a clock edge with reset=1: state=IDLE; busy, done, data_out, ser_out, ser_valid, sat_err, the internal shift register and the index all go to 0. Reset has priority in every state.
- Reset during BUILD aborts the build: no done pulse, and data_out is cleared.
- FSM states: IDLE, BUILD, DONE.
- IDLE, start=1 at edge 0:
  - latch n = min(count_in, DATA_WIDTH);
  - sat_err <= (count_in > DATA_WIDTH);
  - clear the shift register; index <= 0;
  - go to BUILD with busy=1.
- IDLE, start=0: remain in IDLE.
- BUILD, at edges 1..DATA_WIDTH, one shift per edge:
  - bit b = 1 iff index >= DATA_WIDTH - n;
  - shreg <= {shreg[DATA_WIDTH-2:0], b};
  - ser_out <= b; ser_valid <= 1;
  - index <= index + 1.
- The index is an integer or a register of ceil(log2(DATA_WIDTH+1)) bits and must not wrap before reaching DATA_WIDTH.
- At edge DATA_WIDTH, the last shift:
  - data_out <= completed pattern, equal to (1<<n)-1;
  - state <= DONE; busy <= 0; done <= 1.
- ser_valid deasserts at edge DATA_WIDTH+1. ser_out holds its last value when ser_valid=0.
- DONE lasts one cycle. At edge DATA_WIDTH+1: done <= 0; state <= IDLE.
- start is ignored in BUILD and DONE (no queuing). The earliest next acceptance is edge DATA_WIDTH+2, giving a minimum period of DATA_WIDTH+2 cycles.
- Latency: done is high during the cycle following edge DATA_WIDTH after acceptance.
- count_in changes after acceptance have no effect on the pattern in progress.
- n=0 produces all-zero bits; n=DATA_WIDTH produces all-one bits. Both take the full DATA_WIDTH shifts, so latency is independent of the count.
- Serial order: the first bit emitted ends up at the MSB of data_out. Zeros are emitted first, then ones.

Test Plan (DATA_WIDTH=4, COUNT_WIDTH=3):
1. Reset for 2 cycles -> busy=0, done=0, data_out=4'b0000, sat_err=0, ser_valid=0.
2. Start with count_in=3 at edge 0 -> ser_out sequence 0,1,1,1 at edges 1-4; done=1 after edge 4 with data_out=4'b0111; sat_err=0; busy=0 after edge 4.
3. Boundary counts:
   - count_in=0 -> ser_out 0,0,0,0; data_out=0000; done still after edge 4.
   - count_in=4 -> ser_out 1,1,1,1; data_out=1111.
4. Saturation: count_in=6 -> sat_err=1 from edge 0; data_out=1111. A following run with count_in=2 -> sat_err=0, data_out=0011.
5. Reset mid-operation: start count_in=3, assert reset at edge 2 -> busy=0, data_out=0000, no done pulse. A fresh start with count_in=1 -> data_out=0001.
6. Start held high continuously with count_in changing each cycle:
   - only the edge-0 value is used;
   - starts during BUILD and DONE are ignored;
   - the second acceptance occurs at edge 6;
   - done pulses are exactly 6 cycles apart.
